// File: rtl/prbs_checker.sv
// Self-synchronizing checker for an XNOR Fibonacci LFSR bit stream.
// Predicts each bit from the previously received bits, acquires lock, then counts bit errors.
module prbs_checker #(
  parameter int                    STATE_BITS = 4,
  parameter logic [STATE_BITS-1:0] POLYNOMIAL = 4'b1001,
  parameter int                    INPUT_BITS = 2,
  parameter int                    LOCK_COUNT = 8,
  parameter int                    LOSS_COUNT = 4,
  parameter int                    ERR_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [INPUT_BITS-1:0] data_in,
  input  logic                  clr,
  output logic                  locked,
  output logic                  err_pulse,
  output logic [ERR_BITS-1:0]   err_count
);

  localparam int FILL_W = $clog2(STATE_BITS + 1);
  localparam int MIS_W  = $clog2(INPUT_BITS + 1);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(LOSS_COUNT + 1);

  typedef enum logic {HUNT, LOCKED} state_e;

  state_e                state_q, state_d;
  logic [STATE_BITS-1:0] h_q, h_d, h_scan;
  logic [FILL_W-1:0]     fill_q, fill_d, fill_scan;
  logic [GOOD_W-1:0]     good_q, good_d;
  logic [BAD_W-1:0]      bad_q, bad_d;
  logic [ERR_BITS-1:0]   err_q, err_d, err_base;
  logic [ERR_BITS:0]     err_sum;
  logic                  pulse_q, pulse_d;
  logic [MIS_W-1:0]      mis_cnt;
  logic                  all_cmp;
  logic                  pred;
  logic                  word_clean;

  // Walk the word oldest bit first; H always absorbs the received bit, so the
  // checker resynchronizes on its own after any error burst.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned, which would infer a latch.
    h_scan    = h_q;
    fill_scan = fill_q;
    mis_cnt   = '0;
    all_cmp   = 1'b1;
    pred      = 1'b0;
    for (int i = INPUT_BITS - 1; i >= 0; i--) begin
      pred = ~^(h_scan & POLYNOMIAL);
      if (fill_scan == FILL_W'(STATE_BITS)) begin
        if (data_in[i] != pred) mis_cnt = mis_cnt + MIS_W'(1);
      end else begin
        all_cmp   = 1'b0;
        fill_scan = fill_scan + FILL_W'(1);
      end
      h_scan = {h_scan[STATE_BITS-2:0], data_in[i]};
    end
  end

  // All-ones history is the XNOR lockup state: predictions trivially match, so it must not count as clean.
  assign word_clean = all_cmp && (mis_cnt == '0) && (h_q != '1);

  assign err_base = clr ? '0 : err_q;
  assign err_sum  = {1'b0, err_base} + (ERR_BITS + 1)'(mis_cnt);

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    fill_d  = fill_q;
    good_d  = good_q;
    bad_d   = bad_q;
    err_d   = err_base;
    pulse_d = 1'b0;
    if (valid_in) begin
      h_d    = h_scan;
      fill_d = fill_scan;
      unique case (state_q)
        HUNT: begin
          if (!word_clean) begin
            good_d = '0;
          end else if (good_q == GOOD_W'(LOCK_COUNT - 1)) begin
            state_d = LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + GOOD_W'(1);
          end
        end
        LOCKED: begin
          pulse_d = (mis_cnt != '0);
          err_d   = err_sum[ERR_BITS] ? '1 : err_sum[ERR_BITS-1:0];
          if (mis_cnt == '0) begin
            bad_d = '0;
          end else if (bad_q == BAD_W'(LOSS_COUNT - 1)) begin
            state_d = HUNT;
            bad_d   = '0;
            good_d  = '0;
          end else begin
            bad_d = bad_q + BAD_W'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, matching hardware.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HUNT;
      h_q     <= '0;
      fill_q  <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      err_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      fill_q  <= fill_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      pulse_q <= pulse_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = pulse_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: a bit-history model checks both instances every cycle,
// and directed phases pin hand-computed lock, error and saturation values.
module tb_prbs_checker;

  localparam int          SB   = 4;
  localparam logic [3:0]  POLY = 4'b1001;
  localparam int          IB   = 2;
  localparam int          LOCK = 8;
  localparam int          LOSS = 4;

  logic       clk = 1'b0;
  logic       rst_n, valid_in, clr;
  logic [1:0] data_in;
  logic       locked, err_pulse, locked_s, err_pulse_s;
  logic [15:0] err_count;
  logic [3:0]  err_s;

  int n_checks = 0;
  int n_pass   = 0;

  prbs_checker #(.ERR_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
  );

  prbs_checker #(.ERR_BITS(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in), .clr(clr),
    .locked(locked_s), .err_pulse(err_pulse_s), .err_count(err_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: remembers the last SB received bits as a plain list,
  // newest at the back, and applies the lock/loss/count rules word by word.
  int hist[$];
  int m_locked = 0, m_pulse = 0, m_good = 0, m_bad = 0;
  int m_err16 = 0, m_err4 = 0;

  initial begin : compare
    int nm, cmp_all, lockup, p, b;
    forever begin
      @(negedge clk);
      check("locked", locked, m_locked);
      check("err_pulse", err_pulse, m_pulse);
      check("err_count", err_count, m_err16);
      check("locked_sat", locked_s, m_locked);
      check("err_pulse_sat", err_pulse_s, m_pulse);
      check("err_count_sat", err_s, m_err4);
      if (!rst_n) begin
        hist.delete();
        m_locked = 0; m_pulse = 0; m_good = 0; m_bad = 0; m_err16 = 0; m_err4 = 0;
      end else begin
        m_pulse = 0;
        if (clr) begin
          m_err16 = 0;
          m_err4  = 0;
        end
        if (valid_in) begin
          nm      = 0;
          cmp_all = 1;
          lockup  = (hist.size() == SB);
          foreach (hist[k]) if (hist[k] == 0) lockup = 0;
          for (int i = IB - 1; i >= 0; i--) begin
            b = int'(data_in[i]);
            if (hist.size() == SB) begin
              p = 1;
              for (int k = 0; k < SB; k++) if (POLY[k]) p ^= hist[SB-1-k];
              if (b != p) nm++;
            end else begin
              cmp_all = 0;
            end
            hist.push_back(b);
            if (hist.size() > SB) hist.delete(0);
          end
          if (m_locked == 1) begin
            m_err16 = (m_err16 + nm > 65535) ? 65535 : m_err16 + nm;
            m_err4  = (m_err4 + nm > 15) ? 15 : m_err4 + nm;
            m_pulse = (nm != 0) ? 1 : 0;
            if (nm == 0) m_bad = 0;
            else begin
              m_bad++;
              if (m_bad == LOSS) begin
                m_locked = 0; m_bad = 0; m_good = 0;
              end
            end
          end else begin
            if (cmp_all == 1 && nm == 0 && lockup == 0) begin
              m_good++;
              if (m_good == LOCK) begin
                m_locked = 1; m_good = 0;
              end
            end else begin
              m_good = 0;
            end
          end
        end
      end
    end
  end

  // Error-free generator stream (XNOR Fibonacci LFSR, entropy 0).
  logic [3:0] g = 4'b0000;

  task automatic next_word(output logic [1:0] w);
    logic bit_v;
    for (int i = 1; i >= 0; i--) begin
      bit_v = ~^(g & POLY);
      w[i]  = bit_v;
      g     = {g[2:0], bit_v};
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] d, input logic c);
    valid_in = v;
    data_in  = d;
    clr      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] mask, input logic c);
    logic [1:0] w;
    next_word(w);
    drive(1'b1, w ^ mask, c);
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; data_in = 2'b00; clr = 1'b0;
    drive(1'b0, 2'b00, 1'b0);
    drive(1'b0, 2'b00, 1'b0);
    check("reset_locked", locked, 0);
    check("reset_err", err_count, 0);
    check("reset_pulse", err_pulse, 0);
    rst_n = 1'b1;

    // Acquisition: 2 fill words, then 8 clean words.
    for (int w = 1; w <= 10; w++) begin
      send(2'b00, 1'b0);
      check("acq_locked", locked, logic'(w == 10));
    end
    check("acq_err", err_count, 0);

    // Single flipped oldest bit: 2 mismatches now, 1 more two words later.
    send(2'b10, 1'b0);
    check("flip_pulse0", err_pulse, 1);
    check("flip_err0", err_count, 2);
    send(2'b00, 1'b0);
    check("flip_pulse1", err_pulse, 0);
    send(2'b00, 1'b0);
    check("flip_pulse2", err_pulse, 1);
    send(2'b00, 1'b0);
    check("flip_err", err_count, 3);
    check("flip_locked", locked, 1);

    // Loss: flipping the newest bit of every word errors each word (1+2+1+1 bits).
    for (int w = 1; w <= 4; w++) begin
      send(2'b01, 1'b0);
      check("loss_locked", locked, logic'(w < 4));
    end
    check("loss_err", err_count, 8);

    // Clean resume: 2 transition words still mismatch, then 8 clean words.
    for (int w = 1; w <= 10; w++) begin
      send(2'b00, 1'b0);
      check("reacq_locked", locked, logic'(w == 10));
    end
    check("reacq_err", err_count, 8);

    // Saturation: 7 single flips of 3 errors each.
    for (int f = 0; f < 7; f++) begin
      send(2'b10, 1'b0);
      for (int k = 0; k < 3; k++) send(2'b00, 1'b0);
    end
    check("sat_err16", err_count, 29);
    check("sat_err4", err_s, 15);
    check("sat_locked", locked, 1);

    // Clear coincident with a 2-error word.
    send(2'b10, 1'b1);
    check("clr_err16", err_count, 2);
    check("clr_err4", err_s, 2);
    send(2'b00, 1'b0);
    send(2'b00, 1'b0);
    check("clr_tail", err_count, 3);

    // One-cycle reset while locked, then gapped reacquisition.
    rst_n = 1'b0;
    send(2'b00, 1'b0);
    rst_n = 1'b1;
    check("rst_locked", locked, 0);
    check("rst_err", err_count, 0);
    check("rst_err4", err_s, 0);
    for (int w = 1; w <= 10; w++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++)
        drive(1'b0, 2'($urandom_range(0, 3)), 1'b0);
      send(2'b00, 1'b0);
      check("gap_locked", locked, logic'(w == 10));
    end

    // Stuck-ones input from reset must never lock or count.
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) drive(1'b1, 2'b11, 1'b0);
    check("stuck_locked", locked, 0);
    check("stuck_err", err_count, 0);

    drive(1'b0, 2'b00, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timed out");
  end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Self-synchronizing checker for the XNOR Fibonacci LFSR bit stream produced by the team's `prng` block. It sits at the far end of a link or loopback path and consumes INPUT_BITS bits per valid cycle. It acquires lock by predicting each bit from the previous STATE_BITS received bits, then counts bit errors while locked. It is the receive-side counterpart used for link and BIST checks; the generator must run with entropy tied to 0.

## Interface

**Parameters**
- STATE_BITS, 4: LFSR length; must match the generator.
- POLYNOMIAL, 4'b1001: feedback tap mask; must match the generator.
- INPUT_BITS, 2: bits consumed per valid cycle; must equal the generator's OUTPUT_BITS.
- LOCK_COUNT, 8: consecutive clean words required to declare lock.
- LOSS_COUNT, 4: consecutive errored words that drop lock.
- ERR_BITS, 16: width of the error counter.

**Ports**
- clk, input, 1: clock.
- rst_n, input, 1: reset, synchronous, active-low.
- valid_in, input, 1: data_in is valid this cycle.
- data_in, input, INPUT_BITS: received word; bit INPUT_BITS-1 is oldest in time, bit 0 is newest.
- clr, input, 1: synchronous clear of err_count.
- locked, output, 1: checker is in the LOCKED state.
- err_pulse, output, 1: one-cycle flag; the previous valid word had at least one error while LOCKED.
- err_count, output, ERR_BITS: saturating count of mismatched bits seen while LOCKED.

## Operation

**History register**
- H is STATE_BITS wide; H[STATE_BITS-1] is the oldest bit.
- Each bit b of a valid word is processed in time order, from data_in[INPUT_BITS-1] down to data_in[0], all within one cycle:
  - predicted bit p = ~^(H & POLYNOMIAL);
  - the bit mismatches if b != p;
  - H becomes {H[STATE_BITS-2:0], b}.
- H always shifts in the received bit, never the predicted bit. A single flipped line bit therefore yields 1 + (number of set bits in POLYNOMIAL) mismatches.
- fill counts received bits from 0 up to STATE_BITS, then saturates. A bit is compared only when fill == STATE_BITS before that bit.
- A word is clean only if all INPUT_BITS bits were compared, none mismatched, and H before the word is not all-ones. All-ones is the XNOR lockup pattern and must never produce lock.

**State machine**
- HUNT (entered on reset):
  - good counts consecutive clean words; any non-clean valid word sets good to 0.
  - When good would reach LOCK_COUNT, go to LOCKED and set good to 0.
  - err_count is not updated in HUNT.
- LOCKED:
  - Each valid word adds its mismatch count (0..INPUT_BITS) to err_count, saturating at all-ones.
  - A word with mismatches increments bad; a word without mismatches sets bad to 0.
  - When bad would reach LOSS_COUNT, go to HUNT and set bad and good to 0. H and fill are kept.
  - The word that triggers loss of lock is still counted.
- When valid_in is low, H, fill, good, bad, state and err_count all hold, and err_pulse is 0.

**Clear and reset**
- clr zeroes err_count before this cycle's addition: clr together with a word carrying 2 errors gives err_count = 2.
- Reset, including mid-operation: state goes to HUNT; H, fill, good, bad and err_count go to 0; locked = 0 and err_pulse = 0.

## Timing

- All outputs are registered.
- locked rises on the clock edge that samples the LOCK_COUNT-th clean word, so it is visible the cycle after that word.
- With the default parameters and an error-free stream, the first 2 valid words only fill H. Lock is achieved after 10 valid words, and locked is high in the cycle after the 10th.
- err_count and err_pulse update the cycle after the offending word.
- locked falls the cycle after the LOSS_COUNT-th consecutive errored word.
- Throughput is one word per cycle with no backpressure.

## Test plan

1. **Acquisition:** drive a `prng` (same parameters, entropy=0) stream with valid_in always high. Required: locked=0 for the first 10 cycles, locked=1 from cycle 11, err_count stays 0.
2. **Single bit flip while locked:** flip one bit. Required: err_count increases by exactly 3 (default POLYNOMIAL), err_pulse is high for one or two cycles, locked stays 1.
3. **Stuck-ones input:** drive data_in=2'b11 continuously for 50 cycles. Required: locked stays 0 and err_count stays 0.
4. **Loss of lock:** after lock, replace the stream with random data. Required: locked drops after 4 consecutive errored words, then reacquires within 10 words once the clean stream resumes.
5. **Gapped valid, clear and saturation:** toggle valid_in randomly; the lock latency counted in valid words must be unchanged. Assert clr in the same cycle as a 2-error word: err_count must equal 2. Set ERR_BITS=4 and inject 20 errors: err_count must hold at 15.
6. **Reset while locked:** pulse rst_n low for one cycle. Required: locked=0, err_count=0 the next cycle, and reacquisition takes 10 words.
